// File: rtl/instruction_set.sv
// Shared word size, I/O register map and debounce state encoding for the I/O port bank.
package instruction_set;

  localparam int unsigned WORD_SIZE = 8;

  // I/O register map
  localparam logic [3:0] ADDR_BANK0_BASE = 4'd0;
  localparam logic [3:0] ADDR_BANK1_BASE = 4'd3;
  localparam logic [3:0] ADDR_CTRL       = 4'd7;
  localparam logic [3:0] ADDR_BTN_LEVEL  = 4'd8;
  localparam logic [3:0] ADDR_BTN_EDGE   = 4'd9;

  typedef enum logic {
    DB_STABLE   = 1'b0,
    DB_COUNTING = 1'b1
  } db_state_e;

endpackage

// File: rtl/button_debouncer.sv
// One push-button: two-flop synchroniser, then a STABLE/COUNTING FSM that accepts a new
// level only after it has held for DEBOUNCE_CYCLES consecutive cycles.
module button_debouncer
  import instruction_set::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  localparam logic [7:0] CntLast = 8'(DEBOUNCE_CYCLES - 1);

  logic      sync1_q, sync2_q;
  db_state_e state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic      level_q, level_d;

  // Synchroniser for the asynchronous button input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

  // Debounce FSM next state; the counter holds the number of differing cycles seen so far
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    case (state_q)
      DB_STABLE: begin
        if (sync2_q != level_q) begin
          state_d = DB_COUNTING;
          cnt_d   = 8'd1;
        end
      end
      DB_COUNTING: begin
        if (sync2_q == level_q) begin
          state_d = DB_STABLE;
          cnt_d   = 8'd0;
        end else if (cnt_q >= CntLast) begin
          level_d = ~level_q;
          state_d = DB_STABLE;
          cnt_d   = 8'd0;
        end else if (cnt_q != 8'hFF) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = DB_STABLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // Debounce state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DB_STABLE;
      cnt_q   <= 8'd0;
      level_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level = level_q;
  // High in the cycle whose edge raises the debounced level
  assign press = level_d & ~level_q;

endmodule

// File: rtl/io_port_bank.sv
// Processor-visible I/O registers: display banks, control, and debounced push-buttons with
// sticky press latches and a maskable level interrupt.
module io_port_bank
  import instruction_set::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [3:0]                    io_addr,
  input  logic [WORD_SIZE-1:0]          io_wdata,
  input  logic                          io_we,
  input  logic                          io_re,
  output logic [WORD_SIZE-1:0]          io_rdata,
  output logic                          io_rvalid,
  input  logic [3:0]                    buttons_in,
  output logic [2:0][WORD_SIZE-1:0]     bank_0_out,
  output logic [3:0][WORD_SIZE-1:0]     bank_1_out,
  output logic                          bank_sel,
  output logic                          btn_irq
);

  logic [2:0][WORD_SIZE-1:0] bank0_q, bank0_d;
  logic [3:0][WORD_SIZE-1:0] bank1_q, bank1_d;
  logic                      bank_sel_q, bank_sel_d;
  logic [3:0]                mask_q, mask_d;
  logic [3:0]                edge_q, edge_d, edge_clr;
  logic                      irq_q, irq_d;
  logic [WORD_SIZE-1:0]      rdata_q, rd_word;
  logic                      rvalid_q;
  logic [3:0]                btn_level, btn_press;
  logic [1:0]                bank1_idx;

  for (genvar i = 0; i < 4; i++) begin : g_btn
    button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
      .clk    (clk),
      .rst_n  (rst_n),
      .btn_raw(buttons_in[i]),
      .level  (btn_level[i]),
      .press  (btn_press[i])
    );
  end

  // Addresses 3..6 map onto bank_1 entries 0..3 (wraps mod 4 in two bits)
  assign bank1_idx = io_addr[1:0] - ADDR_BANK1_BASE[1:0];

  // Register writes; a press in the same cycle as a clear keeps the edge bit set
  always_comb begin
    bank0_d    = bank0_q;
    bank1_d    = bank1_q;
    bank_sel_d = bank_sel_q;
    mask_d     = mask_q;
    if (io_we) begin
      if (io_addr < ADDR_BANK1_BASE) begin
        bank0_d[io_addr[1:0]] = io_wdata;
      end else if (io_addr < ADDR_CTRL) begin
        bank1_d[bank1_idx] = io_wdata;
      end else if (io_addr == ADDR_CTRL) begin
        bank_sel_d = io_wdata[0];
        mask_d     = io_wdata[7:4];
      end
    end
    edge_clr = (io_we && io_addr == ADDR_BTN_EDGE) ? io_wdata[3:0] : 4'b0000;
    edge_d   = (edge_q & ~edge_clr) | btn_press;
    irq_d    = |(edge_d & mask_d);
  end

  // Read mux over pre-write register values
  always_comb begin
    rd_word = '0;
    if (io_addr < ADDR_BANK1_BASE) begin
      rd_word = bank0_q[io_addr[1:0]];
    end else if (io_addr < ADDR_CTRL) begin
      rd_word = bank1_q[bank1_idx];
    end else begin
      case (io_addr)
        ADDR_CTRL:      rd_word = {mask_q, 3'b000, bank_sel_q};
        ADDR_BTN_LEVEL: rd_word = {4'b0000, btn_level};
        ADDR_BTN_EDGE:  rd_word = {4'b0000, edge_q};
        default:        rd_word = '0;
      endcase
    end
  end

  // Register state, registered read port and interrupt
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank0_q    <= '0;
      bank1_q    <= '0;
      bank_sel_q <= 1'b0;
      mask_q     <= 4'b0000;
      edge_q     <= 4'b0000;
      irq_q      <= 1'b0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
    end else begin
      bank0_q    <= bank0_d;
      bank1_q    <= bank1_d;
      bank_sel_q <= bank_sel_d;
      mask_q     <= mask_d;
      edge_q     <= edge_d;
      irq_q      <= irq_d;
      rvalid_q   <= io_re;
      if (io_re) begin
        rdata_q <= rd_word;
      end
    end
  end

  assign bank_0_out = bank0_q;
  assign bank_1_out = bank1_q;
  assign bank_sel   = bank_sel_q;
  assign btn_irq    = irq_q;
  assign io_rdata   = rdata_q;
  assign io_rvalid  = rvalid_q;

endmodule

// File: tb/tb_io_port_bank.sv
// Directed bench for io_port_bank: register map vectors plus button/reset sequences.
module tb_io_port_bank;

  localparam int unsigned D = 16;

  logic            clk;
  logic            rst_n;
  logic [3:0]      io_addr;
  logic [7:0]      io_wdata;
  logic            io_we;
  logic            io_re;
  logic [7:0]      io_rdata;
  logic            io_rvalid;
  logic [3:0]      buttons_in;
  logic [2:0][7:0] bank_0_out;
  logic [3:0][7:0] bank_1_out;
  logic            bank_sel;
  logic            btn_irq;

  int checks = 0;
  int errors = 0;

  io_port_bank #(
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .io_addr   (io_addr),
    .io_wdata  (io_wdata),
    .io_we     (io_we),
    .io_re     (io_re),
    .io_rdata  (io_rdata),
    .io_rvalid (io_rvalid),
    .buttons_in(buttons_in),
    .bank_0_out(bank_0_out),
    .bank_1_out(bank_1_out),
    .bank_sel  (bank_sel),
    .btn_irq   (btn_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic do_write(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    io_addr  = a;
    io_wdata = d;
    io_we    = 1'b1;
    @(negedge clk);
    io_we = 1'b0;
  endtask

  task automatic do_read(input logic [3:0] a, input logic [7:0] exp, input string name);
    @(negedge clk);
    io_addr = a;
    io_re   = 1'b1;
    @(negedge clk);
    io_re = 1'b0;
    check({name, " rvalid"}, 32'(io_rvalid), 32'd1);
    check({name, " rdata"}, 32'(io_rdata), 32'(exp));
  endtask

  task automatic wait_irq_high(input int maxc, input string name);
    int n = 0;
    while (btn_irq !== 1'b1 && n < maxc) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(btn_irq), 32'd1);
  endtask

  initial begin
    rst_n      = 1'b0;
    io_addr    = 4'd0;
    io_wdata   = 8'h00;
    io_we      = 1'b0;
    io_re      = 1'b0;
    buttons_in = 4'b0000;

    vecs[0]  = '{4'd0,  8'h11, 8'h11};
    vecs[1]  = '{4'd1,  8'h3C, 8'h3C};
    vecs[2]  = '{4'd2,  8'hA5, 8'hA5};
    vecs[3]  = '{4'd3,  8'h5A, 8'h5A};
    vecs[4]  = '{4'd4,  8'hFF, 8'hFF};
    vecs[5]  = '{4'd5,  8'h01, 8'h01};
    vecs[6]  = '{4'd6,  8'h80, 8'h80};
    vecs[7]  = '{4'd7,  8'hFE, 8'hF0};  // CTRL bits[3:1] read as zero
    vecs[8]  = '{4'd7,  8'h31, 8'h31};
    vecs[9]  = '{4'd8,  8'hFF, 8'h00};  // read-only levels, no buttons
    vecs[10] = '{4'd12, 8'h55, 8'h00};
    vecs[11] = '{4'd15, 8'hAA, 8'h00};
    vecs[12] = '{4'd10, 8'h77, 8'h00};
    vecs[13] = '{4'd9,  8'hFF, 8'h00};  // clearing nothing

    // Reset state
    repeat (3) @(negedge clk);
    check("reset rvalid", 32'(io_rvalid), 32'd0);
    check("reset rdata", 32'(io_rdata), 32'd0);
    check("reset irq", 32'(btn_irq), 32'd0);
    check("reset bank0", 32'(bank_0_out), 32'd0);
    check("reset bank1", bank_1_out, 32'd0);
    check("reset bank_sel", 32'(bank_sel), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post-reset rvalid", 32'(io_rvalid), 32'd0);
    check("post-reset irq", 32'(btn_irq), 32'd0);

    // Register map vectors: write then read back
    for (int i = 0; i < 14; i++) begin
      do_write(vecs[i].addr, vecs[i].wdata);
      do_read(vecs[i].addr, vecs[i].exp, $sformatf("vec%0d", i));
    end
    @(negedge clk);
    check("rvalid drops", 32'(io_rvalid), 32'd0);
    check("rdata holds", 32'(io_rdata), 32'd0);
    check("bank_0_out[1]", 32'(bank_0_out[1]), 32'h3C);
    check("bank_1_out[3]", 32'(bank_1_out[3]), 32'h80);
    check("bank_1_out[0]", 32'(bank_1_out[0]), 32'h5A);
    check("bank_sel", 32'(bank_sel), 32'd1);

    // Simultaneous read and write returns the old value
    @(negedge clk);
    io_addr  = 4'd0;
    io_wdata = 8'h77;
    io_we    = 1'b1;
    io_re    = 1'b1;
    @(negedge clk);
    io_we = 1'b0;
    io_re = 1'b0;
    check("rw same addr rdata", 32'(io_rdata), 32'h11);
    check("rw same addr bank", 32'(bank_0_out[0]), 32'h77);

    // Button 0 press with mask 0x3
    buttons_in[0] = 1'b1;
    wait_irq_high(D + 8, "btn0 irq");
    do_read(4'd8, 8'h01, "btn0 level");
    do_read(4'd9, 8'h01, "btn0 edge");

    // Short glitch on button 2 is rejected
    @(negedge clk);
    buttons_in[2] = 1'b1;
    repeat (5) @(negedge clk);
    buttons_in[2] = 1'b0;
    repeat (D + 8) @(negedge clk);
    do_read(4'd8, 8'h01, "glitch level");
    do_read(4'd9, 8'h01, "glitch edge");

    // Release button 0: level falls, edge stays latched
    buttons_in[0] = 1'b0;
    repeat (D + 8) @(negedge clk);
    do_read(4'd8, 8'h00, "release level");
    do_read(4'd9, 8'h01, "release edge");

    // Hold a clear-write on BTN_EDGE every cycle while button 0 is pressed again
    @(negedge clk);
    io_addr       = 4'd9;
    io_wdata      = 8'h01;
    io_we         = 1'b1;
    buttons_in[0] = 1'b1;
    @(negedge clk);
    check("clear drops irq", 32'(btn_irq), 32'd0);
    wait_irq_high(D + 10, "set wins over clear");
    @(negedge clk);
    check("repeat clear drops irq", 32'(btn_irq), 32'd0);
    io_we = 1'b0;
    do_read(4'd9, 8'h00, "edge cleared");

    // Reset mid-debounce with registers nonzero; button 1 held through release
    buttons_in[0] = 1'b0;
    buttons_in[1] = 1'b1;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst bank0", 32'(bank_0_out), 32'd0);
    check("rst bank1", bank_1_out, 32'd0);
    check("rst bank_sel", 32'(bank_sel), 32'd0);
    check("rst rdata", 32'(io_rdata), 32'd0);
    check("rst rvalid", 32'(io_rvalid), 32'd0);
    check("rst irq", 32'(btn_irq), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do_write(4'd7, 8'h20);
    check("release rvalid", 32'(io_rvalid), 32'd0);
    check("release irq", 32'(btn_irq), 32'd0);
    repeat (D - 2) @(negedge clk);
    check("no early press after reset", 32'(btn_irq), 32'd0);
    wait_irq_high(12, "held-through-reset press");
    do_read(4'd8, 8'h02, "held level");
    do_read(4'd9, 8'h02, "held edge");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
